conv_window_gen: RTL and testbench

Parametrised sliding-window generator feeding the NPU MAC array in the convolution datapath. It is the successor to the fixed depthwise pre-processing stage. It accepts a raster stream of CH_NUM-channel pixels and emits 3x3xCH_NUM windows. Frame width and height, stride (1/2) and optional zero padding are set at run time, and both sides use valid/ready backpressure.

---
 rtl/conv_pkg.sv | 21 ++
 rtl/conv_line_buf.sv | 26 ++
 rtl/conv_window_gen.sv | 209 ++++++++++++++++++++
 tb/tb_conv_window_gen.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution window generator.
package conv_pkg;

  localparam int KERNEL = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    STRIDE_1 = 1'b0,
    STRIDE_2 = 1'b1
  } stride_e;

  function automatic int win_bits(input int dw, input int ch);
    return KERNEL * KERNEL * ch * dw;
  endfunction

endpackage

// File: rtl/conv_line_buf.sv
// Single-port-address line buffer: combinational read, registered write,
// so a read at the write address returns the previous row's sample.
module conv_line_buf #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 322,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  // storage write
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// 3x3xCH_NUM sliding-window generator over a raster pixel stream, stride 1 or 2.
// Zero border padding (cfg_pad) is only built in when CONV_WIN_PAD_EN is defined.
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CH_NUM     = 9,
  parameter int MAX_WIDTH  = 320,
  parameter int DIM_BITS   = 10
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic [DIM_BITS-1:0]                    cfg_width,
  input  logic [DIM_BITS-1:0]                    cfg_height,
  input  logic                                   cfg_stride2,
  input  logic                                   cfg_pad,
  input  logic                                   start,
  output logic                                   busy,
  output logic                                   done,
  input  logic [CH_NUM*DATA_WIDTH-1:0]           pix_in,
  input  logic                                   pix_valid,
  output logic                                   pix_ready,
  output logic [win_bits(DATA_WIDTH,CH_NUM)-1:0] win_out,
  output logic                                   win_valid,
  input  logic                                   win_ready
);

  localparam int PIX_W = CH_NUM * DATA_WIDTH;
  localparam int TAPS  = KERNEL * KERNEL;
`ifdef CONV_WIN_PAD_EN
  localparam int LB_DEPTH = MAX_WIDTH + 2;
`else
  localparam int LB_DEPTH = MAX_WIDTH;
`endif
  localparam int LB_AW = $clog2(LB_DEPTH);
  localparam logic [DIM_BITS-1:0] D_ZERO  = DIM_BITS'(0);
  localparam logic [DIM_BITS-1:0] D_ONE   = DIM_BITS'(1);
  localparam logic [DIM_BITS-1:0] D_TWO   = DIM_BITS'(2);
  localparam logic [DIM_BITS-1:0] D_THREE = DIM_BITS'(3);

  state_e                     state_q, state_d;
  stride_e                    stride_q, stride_d;
  logic [DIM_BITS-1:0]        wv_q, wv_d, hv_q, hv_d, vr_q, vr_d, vc_q, vc_d;
  logic                       walked_q, walked_d, busy_q, busy_d, done_q, done_d;
  logic                       win_valid_q, win_valid_d;
  logic [TAPS-1:0][PIX_W-1:0] sr_q, sr_d;
  logic [PIX_W-1:0]           lb0_rd, lb1_rd, pix_eff;
  logic [DIM_BITS-1:0]        pad_ext;
  logic                       interior, degenerate, slot_free, can_walk, advance, last_pos, emit;

`ifdef CONV_WIN_PAD_EN
  logic pad_q, pad_d;

  // border detection on the virtual (padded) frame
  always_comb begin
    pad_ext  = {{(DIM_BITS-2){1'b0}}, cfg_pad, 1'b0};
    interior = !pad_q || ((vr_q != D_ZERO) && (vr_q != hv_q - D_ONE) &&
                          (vc_q != D_ZERO) && (vc_q != wv_q - D_ONE));
  end
`else
  logic unused_cfg_pad;
  assign unused_cfg_pad = cfg_pad;

  // without padding every position is a real input pixel
  always_comb begin
    pad_ext  = D_ZERO;
    interior = 1'b1;
  end
`endif

  // position availability and window-emission decode
  always_comb begin
    degenerate = (wv_q < D_THREE) || (hv_q < D_THREE);
    slot_free  = !win_valid_q || win_ready;
    can_walk   = (state_q == ST_RUN) && !degenerate && !walked_q && slot_free;
    advance    = can_walk && (!interior || pix_valid);
    pix_ready  = can_walk && interior;
    pix_eff    = interior ? pix_in : {PIX_W{1'b0}};
    last_pos   = (vr_q == hv_q - D_ONE) && (vc_q == wv_q - D_ONE);
    emit       = (vr_q >= D_TWO) && (vc_q >= D_TWO) &&
                 ((stride_q == STRIDE_1) || (!vr_q[0] && !vc_q[0]));
  end

  conv_line_buf #(.WIDTH(PIX_W), .DEPTH(LB_DEPTH), .AW(LB_AW)) u_lb0 (
    .clk(clk), .we(advance), .addr(vc_q[LB_AW-1:0]), .wdata(lb1_rd), .rdata(lb0_rd)
  );

  conv_line_buf #(.WIDTH(PIX_W), .DEPTH(LB_DEPTH), .AW(LB_AW)) u_lb1 (
    .clk(clk), .we(advance), .addr(vc_q[LB_AW-1:0]), .wdata(pix_eff), .rdata(lb1_rd)
  );

  // next-state: raster walk, column shift register, output slot and FSM
  always_comb begin
    state_d  = state_q;
    stride_d = stride_q;
    wv_d     = wv_q;
    hv_d     = hv_q;
    vr_d     = vr_q;
    vc_d     = vc_q;
    walked_d = walked_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sr_d     = sr_q;
`ifdef CONV_WIN_PAD_EN
    pad_d    = pad_q;
`endif
    if (advance) begin
      for (int r = 0; r < KERNEL; r++) begin
        sr_d[r*KERNEL]     = sr_q[r*KERNEL+1];
        sr_d[r*KERNEL + 1] = sr_q[r*KERNEL+2];
      end
      sr_d[2] = lb0_rd;
      sr_d[5] = lb1_rd;
      sr_d[8] = pix_eff;
      win_valid_d = emit;
      if (last_pos) begin
        walked_d = 1'b1;
      end else if (vc_q == wv_q - D_ONE) begin
        vc_d = D_ZERO;
        vr_d = vr_q + D_ONE;
      end else begin
        vc_d = vc_q + D_ONE;
      end
    end else if (win_ready) begin
      win_valid_d = 1'b0;
    end else begin
      win_valid_d = win_valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          busy_d      = 1'b1;
          stride_d    = stride_e'(cfg_stride2);
          wv_d        = cfg_width + pad_ext;
          hv_d        = cfg_height + pad_ext;
          vr_d        = D_ZERO;
          vc_d        = D_ZERO;
          walked_d    = 1'b0;
          win_valid_d = 1'b0;
`ifdef CONV_WIN_PAD_EN
          pad_d       = cfg_pad;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // finish once every position is walked and no window is left pending
        if (degenerate || ((walked_q || (advance && last_pos)) && !win_valid_d)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      stride_q    <= STRIDE_1;
      wv_q        <= D_ZERO;
      hv_q        <= D_ZERO;
      vr_q        <= D_ZERO;
      vc_q        <= D_ZERO;
      walked_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      win_valid_q <= 1'b0;
      sr_q        <= '0;
`ifdef CONV_WIN_PAD_EN
      pad_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      stride_q    <= stride_d;
      wv_q        <= wv_d;
      hv_q        <= hv_d;
      vr_q        <= vr_d;
      vc_q        <= vc_d;
      walked_q    <= walked_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      win_valid_q <= win_valid_d;
      sr_q        <= sr_d;
`ifdef CONV_WIN_PAD_EN
      pad_q       <= pad_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign win_valid = win_valid_q;
  assign win_out   = sr_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed-sequence bench for conv_window_gen with randomized pixels/handshakes,
// checked against a padded-frame window model (pad honoured only with CONV_WIN_PAD_EN).
module tb_conv_window_gen;

  localparam int DATA_WIDTH = 8;
  localparam int CH_NUM     = 9;
  localparam int MAX_WIDTH  = 320;
  localparam int DIM_BITS   = 10;
  localparam int PIX_W      = CH_NUM * DATA_WIDTH;
  localparam int WIN_W      = 9 * PIX_W;
`ifdef CONV_WIN_PAD_EN
  localparam bit PAD_ON = 1'b1;
`else
  localparam bit PAD_ON = 1'b0;
`endif

  logic                clk;
  logic                rstn;
  logic [DIM_BITS-1:0] cfg_width, cfg_height;
  logic                cfg_stride2, cfg_pad, start;
  logic                busy, done;
  logic [PIX_W-1:0]    pix_in;
  logic                pix_valid, pix_ready;
  logic [WIN_W-1:0]    win_out;
  logic                win_valid, win_ready;

  conv_window_gen #(
    .DATA_WIDTH(DATA_WIDTH), .CH_NUM(CH_NUM), .MAX_WIDTH(MAX_WIDTH), .DIM_BITS(DIM_BITS)
  ) dut (
    .clk(clk), .rstn(rstn), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_stride2(cfg_stride2), .cfg_pad(cfg_pad), .start(start), .busy(busy), .done(done),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .win_out(win_out), .win_valid(win_valid), .win_ready(win_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int               checks   = 0;
  int               failures = 0;
  logic [PIX_W-1:0] frame [0:63];
  logic [WIN_W-1:0] exp_q [$];
  logic [WIN_W-1:0] rx_q  [$];
  logic [WIN_W-1:0] zero_w;
  bit               rdy_seen;

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_p(input string tag, input logic [PIX_W-1:0] obs, input logic [PIX_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [WIN_W-1:0] obs, input logic [WIN_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PIX_W-1:0] ramp_px(input int i);
    return {CH_NUM{DATA_WIDTH'(i)}};
  endfunction

  function automatic logic [PIX_W-1:0] tap(input logic [WIN_W-1:0] w, input int k);
    return w[k*PIX_W +: PIX_W];
  endfunction

  // Sample at virtual coordinate (r,c) of the frame surrounded by p zero pixels.
  function automatic logic [PIX_W-1:0] vpix(input int r, input int c, input int w, input int h, input int p);
    if (r < p || r >= h + p || c < p || c >= w + p) return '0;
    return frame[(r - p) * w + (c - p)];
  endfunction

  // Reference: every 3x3 window of the virtual frame at stride s, raster order.
  task automatic build_expected(input int w, input int h, input bit s2, input bit pad, output int exp_pix);
    int p, wv, hv, s;
    logic [WIN_W-1:0] win;
    p  = (PAD_ON && pad) ? 1 : 0;
    wv = w + 2 * p;
    hv = h + 2 * p;
    s  = s2 ? 2 : 1;
    exp_q.delete();
    exp_pix = (wv < 3 || hv < 3) ? 0 : w * h;
    if (wv >= 3 && hv >= 3) begin
      for (int top = 0; top + 3 <= hv; top += s) begin
        for (int left = 0; left + 3 <= wv; left += s) begin
          win = '0;
          for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
              win[(r*3+c)*PIX_W +: PIX_W] = vpix(top + r, left + c, w, h, p);
          exp_q.push_back(win);
        end
      end
    end
  endtask

  task automatic fill_ramp(input int n);
    for (int i = 0; i < n; i++) frame[i] = ramp_px(i);
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) frame[i] = PIX_W'({$urandom(), $urandom(), $urandom()});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_b({tag, "/busy"}, busy, 1'b0);
    chk_b({tag, "/done"}, done, 1'b0);
    chk_b({tag, "/pix_ready"}, pix_ready, 1'b0);
    chk_b({tag, "/win_valid"}, win_valid, 1'b0);
    chk_w({tag, "/win_out"}, win_out, zero_w);
  endtask

  // Runs one frame; cycle t counts clock edges after the edge that sampled start.
  task automatic run_frame(input string tag, input int w, input int h, input bit s2, input bit pad,
                           input bit rnd_v, input bit rnd_r, input bit do_stall,
                           input int exp_n, input int exp_done_cyc, input int exp_first_cyc);
    int npix, exp_pix, idx, got, done_cyc, first_cyc, stall_left;
    bit stalled, stall_chk, finished;
    logic [WIN_W-1:0] held;
    npix = w * h;
    build_expected(w, h, s2, pad, exp_pix);
    rx_q.delete();
    idx = 0; got = 0; done_cyc = -1; first_cyc = -1; stall_left = 0;
    stalled = 1'b0; finished = 1'b0; rdy_seen = 1'b0; held = '0;
    @(posedge clk); #1;
    cfg_width = DIM_BITS'(w); cfg_height = DIM_BITS'(h);
    cfg_stride2 = s2; cfg_pad = pad; start = 1'b1; pix_valid = 1'b0; win_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < 4000 && !finished; t++) begin
      pix_valid = (idx < npix) && (!rnd_v || ($urandom_range(0, 3) != 0));
      pix_in    = (idx < npix) ? frame[idx] : '0;
      if (do_stall && !stalled && win_valid && got >= 2) begin
        stalled = 1'b1; stall_left = 5; held = win_out;
      end
      stall_chk = (stall_left > 0);
      if (stall_chk) begin
        win_ready = 1'b0;
        stall_left--;
      end else begin
        win_ready = !rnd_r || ($urandom_range(0, 2) != 0);
      end
      @(negedge clk);
      if (t == 0) chk_b({tag, "/busy_rise"}, busy, 1'b1);
      if (stall_chk) begin
        chk_w({tag, "/stall_hold"}, win_out, held);
        chk_b({tag, "/stall_valid"}, win_valid, 1'b1);
        chk_b({tag, "/stall_pix_ready"}, pix_ready, 1'b0);
      end
      if (pix_ready) rdy_seen = 1'b1;
      if (pix_valid && pix_ready) idx++;
      if (win_valid && win_ready) begin
        if (first_cyc < 0) first_cyc = t;
        rx_q.push_back(win_out);
        if (got < exp_q.size()) chk_w($sformatf("%s/win%0d", tag, got), win_out, exp_q[got]);
        got++;
      end
      if (done) begin
        finished = 1'b1;
        done_cyc = t;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk_b({tag, "/done_seen"}, finished, 1'b1);
    chk_i({tag, "/windows"}, got, exp_n);
    chk_i({tag, "/pixels"}, idx, exp_pix);
    if (exp_done_cyc >= 0) chk_i({tag, "/done_cycle"}, done_cyc, exp_done_cyc);
    if (exp_first_cyc >= 0) chk_i({tag, "/first_win_cycle"}, first_cyc, exp_first_cyc);
    if (do_stall) chk_b({tag, "/stall_hit"}, stalled, 1'b1);
    pix_valid = 1'b0;
    @(posedge clk); #1;
    chk_b({tag, "/done_one_cycle"}, done, 1'b0);
    chk_b({tag, "/busy_idle"}, busy, 1'b0);
  endtask

  initial begin
    int tl [4] = '{0, 2, 12, 14};
    int ids [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    zero_w = '0;
    rstn = 1'b0; cfg_width = '0; cfg_height = '0; cfg_stride2 = 1'b0; cfg_pad = 1'b0;
    start = 1'b0; pix_in = '0; pix_valid = 1'b0; win_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rstn = 1'b1;

    // 5x4 ramp, stride 1: six windows, first is pixels 0,1,2/5,6,7/10,11,12
    fill_ramp(20);
    run_frame("ramp5x4", 5, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6, 21, 13);
    for (int k = 0; k < 9; k++)
      chk_p($sformatf("ramp5x4/first_tap%0d", k), tap(rx_q[0], k), ramp_px(ids[k]));

    // 4x4 with pad request
    fill_rand(16);
    run_frame("pad4x4", 4, 4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, PAD_ON ? 16 : 4, -1, -1);
`ifdef CONV_WIN_PAD_EN
    for (int k = 0; k < 4; k++)
      chk_p($sformatf("pad4x4/border_tap%0d", k), tap(rx_q[0], k), '0);
    chk_p("pad4x4/border_tap6", tap(rx_q[0], 6), '0);
    chk_p("pad4x4/centre", tap(rx_q[0], 4), frame[0]);
`endif

    // 6x6 stride 2: trailing row/column discarded
    fill_rand(36);
    run_frame("s2_6x6", 6, 6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4, -1, -1);
    for (int k = 0; k < 4; k++)
      chk_p($sformatf("s2_6x6/topleft%0d", k), tap(rx_q[k], 0), frame[tl[k]]);

    // downstream stall of five cycles mid-frame
    fill_rand(25);
    run_frame("bp5x5", 5, 5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9, -1, -1);

    // reset in the middle of a frame, then the ramp frame again
    fill_ramp(20);
    @(posedge clk); #1;
    cfg_width = DIM_BITS'(5); cfg_height = DIM_BITS'(4); cfg_stride2 = 1'b0; cfg_pad = 1'b0;
    start = 1'b1; win_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; pix_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      pix_in = frame[k];
      @(posedge clk); #1;
    end
    rstn = 1'b0;
    @(posedge clk); #1;
    chk_reset_outputs("midreset");
    pix_valid = 1'b0;
    @(posedge clk); #1;
    chk_reset_outputs("midreset_hold");
    rstn = 1'b1;
    run_frame("rerun5x4", 5, 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6, 21, 13);

    // degenerate 2x5: done on the first RUN cycle, nothing consumed
    fill_rand(10);
    run_frame("degen2x5", 2, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, -1);
    chk_b("degen2x5/pix_ready_never", rdy_seen, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
